ula_op_sequencer: RTL and testbench
===================================

Name: ula_op_sequencer

Overview:
Sequences one ULA operation per start request. It captures operands and the selector from the board inputs, drives them into the combinational ULA, and waits a programmable settle time before registering the result. Division is executed internally as a 4-iteration restoring divider. The block classifies the error condition and holds result, error flag and error code for the display/LEDR9 path.

Parameters:
SETTLE_CYCLES, 1, cycles in EXEC before alu_result is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request pulse (debounced key); sampled only in IDLE
a_in  input  4  operand A from switches
b_in  input  4  operand B from switches
sel_in  input  3  operation selector (000..110 valid, 001 = subtraction, 110 = division, 111 = unused)
alu_result  input  8  combinational ULA output, computed from op_a/op_b/op_sel
alu_sub_neg  input  1  ULA indication that the subtraction result is negative
op_a  output  4  registered operand A to the ULA
op_b  output  4  registered operand B to the ULA
op_sel  output  3  registered selector to the ULA
busy  output  1  high in EXEC and DIV
done  output  1  one-cycle pulse in DONE
result  output  8  registered result; division returns {remainder[3:0], quotient[3:0]}
err  output  1  OR of err_code bits; drives LEDR9
err_code  output  2  00 none, 01 divide by zero, 10 invalid op, 11 negative subtraction

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0. Reset during EXEC/DIV aborts the operation: no done pulse, and result/err are cleared.
- IDLE, start=1: op_a<=a_in, op_b<=b_in, op_sel<=sel_in. Classification uses the captured inputs:
  - sel_in=111: err_code<=10, result<=0, go to DONE.
  - sel_in=110 and b_in=0000: err_code<=01, result<=0, go to DONE.
  - sel_in=110, b nonzero: load R=0 (5b) and Q=a_in, set iteration counter to 4, go to DIV.
  - Otherwise: load settle counter with SETTLE_CYCLES, go to EXEC.
- EXEC: stays exactly SETTLE_CYCLES cycles. On the last cycle: result<=alu_result; err_code<=11 if op_sel=001 and alu_sub_neg=1, else 00. Then go to DONE.
- DIV: 4 cycles, one step per cycle:
  - Shift {R,Q} left by 1.
  - If R>=op_b: R<=R-op_b and Q[0]<=1.
  - After step 4: result<={R[3:0],Q}, err_code<=00. Then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- result, err and err_code update only at DONE entry. They hold until the next operation reaches DONE or until reset.
- op_a/op_b/op_sel hold from capture until the next accepted start.
- start in EXEC, DIV or DONE is ignored and not queued.
- Latency, counting from the edge T that samples start:
  - error ops: done high in cycle T+1.
  - ALU ops: done high in cycle T+1+SETTLE_CYCLES.
  - division: done high in cycle T+5.
- Throughput: a new start is accepted in the cycle after DONE.

Optional Feature:
ULA_ERR_STICKY_EN:
- Defined: err and err_code are sticky. Once nonzero, they keep the first error's code through later successful operations; only rst clears them. result still updates on every op.
- Undefined: err and err_code reflect only the most recent operation, as described above.

Test Plan:
- rst; a=5 b=3 sel=000, bench models alu_result=a+b, SETTLE_CYCLES=1 -> busy for 1 cycle, done at T+2, result=0x08, err=0, err_code=00.
- a=3 b=5 sel=001, alu_sub_neg=1 -> done at T+2, err=1, err_code=11, result=alu_result.
- a=13 b=4 sel=110 -> busy 4 cycles, done at T+5, result=0x13 (rem 1, quot 3), err=0; a=15 b=1 -> result=0x0F.
- a=7 b=0 sel=110 -> done at T+1, result=0x00, err_code=01; then sel=111 -> done at T+1, err_code=10.
- start pulses during DIV -> ignored, exactly one done; rst asserted at DIV cycle 2 -> busy=0 immediately, no done, outputs 0.
- ULA_ERR_STICKY_EN defined: b=0 div (err_code 01), then 2+2 add -> result=0x04, err_code stays 01 until rst.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// Operation sequencer for the board ULA: captures operands, waits for the ULA to settle
// or runs a 4-step restoring divide, then holds result/error. Sticky errors: ULA_ERR_STICKY_EN.
module ula_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [2:0] sel_in,
  input  logic [7:0] alu_result,
  input  logic       alu_sub_neg,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [2:0] op_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] DIV_STEPS = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [2:0] op_sel_q, op_sel_d;
  logic [7:0] result_q, result_d;
  logic [1:0] err_code_q, err_code_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;

  logic [4:0] rem_shift, rem_step;
  logic [3:0] quo_step;

  function automatic logic [1:0] merge_err(input logic [1:0] cur, input logic [1:0] nxt);
`ifdef ULA_ERR_STICKY_EN
    return (cur != 2'b00) ? cur : nxt;
`else
    return nxt;
`endif
  endfunction

  // One restoring-divide step on the current partial remainder/quotient.
  always_comb begin
    rem_shift = {rem_q[3:0], quo_q[3]};
    quo_step  = {quo_q[2:0], 1'b0};
    rem_step  = rem_shift;
    if (rem_shift >= {1'b0, op_b_q}) begin
      rem_step    = rem_shift - {1'b0, op_b_q};
      quo_step[0] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d   = a_in;
          op_b_d   = b_in;
          op_sel_d = sel_in;
          if (sel_in == 3'b111) begin
            err_code_d = merge_err(err_code_q, 2'b10);
            result_d   = 8'h00;
            state_d    = S_DONE;
          end else if (sel_in == 3'b110 && b_in == 4'd0) begin
            err_code_d = merge_err(err_code_q, 2'b01);
            result_d   = 8'h00;
            state_d    = S_DONE;
          end else if (sel_in == 3'b110) begin
            rem_d   = 5'd0;
            quo_d   = a_in;
            cnt_d   = DIV_STEPS;
            state_d = S_DIV;
          end else begin
            cnt_d   = SETTLE_LD;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q <= 4'd1) begin
          result_d   = alu_result;
          err_code_d = merge_err(err_code_q,
                                 (op_sel_q == 3'b001 && alu_sub_neg) ? 2'b11 : 2'b00);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q <= 4'd1) begin
          result_d   = {rem_step[3:0], quo_step};
          err_code_d = merge_err(err_code_q, 2'b00);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      op_sel_q   <= 3'd0;
      result_q   <= 8'h00;
      err_code_q <= 2'b00;
      cnt_q      <= 4'd0;
      rem_q      <= 5'd0;
      quo_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_sel   = op_sel_q;
  assign result   = result_q;
  assign err_code = err_code_q;
  assign err      = |err_code_q;
  assign busy     = (state_q == S_EXEC) || (state_q == S_DIV);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Self-checking bench for ula_op_sequencer: directed plan steps plus randomized operations
// checked against an arithmetic reference model; also models the combinational ULA.
module tb_ula_op_sequencer;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in, b_in;
  logic [2:0] sel_in;
  logic [7:0] alu_result;
  logic       alu_sub_neg;
  logic [3:0] op_a, op_b;
  logic [2:0] op_sel;
  logic       busy, done, err;
  logic [7:0] result;
  logic [1:0] err_code;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_miss = 0;
  logic [1:0] m_err = 2'b00;

  ula_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .sel_in(sel_in),
    .alu_result(alu_result), .alu_sub_neg(alu_sub_neg),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .busy(busy), .done(done),
    .result(result), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ula(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic [7:0] xa, xb;
    xa = {4'd0, a};
    xb = {4'd0, b};
    case (s)
      3'd0:    return xa + xb;
      3'd1:    return xa - xb;
      3'd2:    return xa & xb;
      3'd3:    return xa | xb;
      3'd4:    return xa ^ xb;
      3'd5:    return xa * xb;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result  = ula(op_a, op_b, op_sel);
  assign alu_sub_neg = (op_sel == 3'b001) && (op_a < op_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_op_a"}, 32'(op_a), 32'd0);
  endtask

  // Reference: latency, result and error code follow directly from the operation rules.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input bit inj);
    int lat;
    logic [1:0] code;
    logic [7:0] res;
    logic [3:0] q, r;
    if (s == 3'd7) begin
      lat = 1; code = 2'b10; res = 8'h00;
    end else if (s == 3'd6 && b == 4'd0) begin
      lat = 1; code = 2'b01; res = 8'h00;
    end else if (s == 3'd6) begin
      q = a / b;
      r = a % b;
      lat = 5; code = 2'b00; res = {r, q};
    end else begin
      lat = 1 + SETTLE;
      res = ula(a, b, s);
      code = (s == 3'd1 && a < b) ? 2'b11 : 2'b00;
    end
`ifdef ULA_ERR_STICKY_EN
    if (m_err == 2'b00) m_err = code;
`else
    m_err = code;
`endif
    n_vec++;
    @(negedge clk);
    a_in = a; b_in = b; sel_in = s; start = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = inj;
      if (inj) begin
        a_in = 4'($urandom_range(0, 15));
        sel_in = 3'($urandom_range(0, 7));
      end
      check("busy", 32'(busy), 32'(k < lat));
      check("done", 32'(done), 32'(k == lat));
    end
    check("result", 32'(result), 32'(res));
    check("err_code", 32'(err_code), 32'(m_err));
    check("err", 32'(err), 32'(m_err != 2'b00));
    check("op_a", 32'(op_a), 32'(a));
    check("op_b", 32'(op_b), 32'(b));
    check("op_sel", 32'(op_sel), 32'(s));
    @(negedge clk);
    start = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("no_queue_busy", 32'(busy), 32'd0);
    check("hold_result", 32'(result), 32'(res));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = 4'd0; b_in = 4'd0; sel_in = 3'd0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    run_op(4'd5, 4'd3, 3'd0, 1'b0);
    run_op(4'd3, 4'd5, 3'd1, 1'b0);
    run_op(4'd13, 4'd4, 3'd6, 1'b0);
    run_op(4'd15, 4'd1, 3'd6, 1'b0);
    run_op(4'd7, 4'd0, 3'd6, 1'b0);
    run_op(4'd2, 4'd2, 3'd0, 1'b0);
    run_op(4'd9, 4'd6, 3'd7, 1'b0);
    run_op(4'd14, 4'd3, 3'd6, 1'b1);

    // Reset in the second DIV cycle aborts the divide.
    n_vec++;
    @(negedge clk);
    a_in = 4'd11; b_in = 4'd2; sel_in = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("div_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("abort");
    m_err = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_abort_done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      logic [2:0] rs;
      ra = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      run_op(ra, rb, rs, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
